// File: rtl/frame_cell_fetch.sv
// frame_cell_fetch: AXI4 write-slave that captures one 320x240 8-bit frame
// into an internal buffer, then re-reads it and delivers 8x8 cells (with an
// optional 1-pixel halo) to IP_AMT output lanes over valid/ready.
// Build option: define FRAME_CELL_FETCH_HALO_EN to fetch the halo pixels;
// otherwise pixels 64..95 of every cell are zero.
module frame_cell_fetch #(
    parameter int unsigned IP_AMT          = 1,
    parameter int unsigned MST_ID_W        = 3,
    parameter int unsigned DATA_WIDTH      = 256,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned TRANS_WR_RESP_W = 2,
    parameter int unsigned PG_WIDTH        = 256,
    parameter int unsigned CELL_WIDTH      = 768,
    parameter int unsigned CELL_NUM        = 1200,
    parameter int unsigned FRAME_ROW_CNUM  = 30,
    parameter int unsigned FRAME_COL_CNUM  = 40,
    parameter int unsigned CELL_ROW_PNUM   = 8,
    parameter int unsigned CELL_COL_PNUM   = 8,
    parameter int unsigned FRAME_COL_PGNUM = FRAME_COL_CNUM / 4
) (
    input  logic                          ACLK_i,
    input  logic                          ARESETn_i,
    input  logic [MST_ID_W-1:0]           m_AWID_i,
    input  logic [ADDR_WIDTH-1:0]         m_AWADDR_i,
    input  logic                          m_AWVALID_i,
    output logic                          m_AWREADY_o,
    input  logic [DATA_WIDTH-1:0]         m_WDATA_i,
    input  logic                          m_WLAST_i,
    input  logic                          m_WVALID_i,
    output logic                          m_WREADY_o,
    output logic [MST_ID_W-1:0]           m_BID_o,
    output logic [TRANS_WR_RESP_W-1:0]    m_BRESP_o,
    output logic                          m_BVALID_o,
    input  logic                          m_BREADY_i,
    output logic [IP_AMT*CELL_WIDTH-1:0]  cell_data_o,
    output logic [IP_AMT-1:0]             cell_valid_o,
    input  logic [IP_AMT-1:0]             cell_ready_i
);

`ifdef FRAME_CELL_FETCH_HALO_EN
    localparam int unsigned HALO = 1;
`else
    localparam int unsigned HALO = 0;
`endif

    localparam int unsigned FRAME_ROW_PNUM = FRAME_ROW_CNUM * CELL_ROW_PNUM;
    localparam int unsigned WORD_NUM       = FRAME_ROW_PNUM * FRAME_COL_PGNUM;
    localparam int unsigned WADDR_W        = $clog2(WORD_NUM);
    localparam int unsigned CELL_CNT_W     = $clog2(CELL_NUM);
    localparam int unsigned ROW_W          = $clog2(FRAME_ROW_CNUM);
    localparam int unsigned COL_W          = $clog2(FRAME_COL_CNUM);
    localparam int unsigned LANE_W         = (IP_AMT > 1) ? $clog2(IP_AMT) : 1;
    localparam int unsigned PG_PNUM        = PG_WIDTH / 8;
    localparam int unsigned CELLS_PER_PG   = PG_PNUM / CELL_COL_PNUM;
    localparam int unsigned ROWS           = CELL_ROW_PNUM + 2 * HALO;
    localparam int unsigned WORDS          = 1 + 2 * HALO;
    localparam int unsigned SEG_W          = (CELL_COL_PNUM + 2 * HALO) * 8;
    localparam int unsigned CROW_W         = CELL_COL_PNUM * 8;
    localparam int unsigned TOP_BASE       = CELL_ROW_PNUM * CROW_W;
    localparam int unsigned BOT_BASE       = TOP_BASE + CROW_W;
    localparam int unsigned LEFT_BASE      = BOT_BASE + CROW_W;
    localparam int unsigned RIGHT_BASE     = LEFT_BASE + CELL_ROW_PNUM * 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_FREAD = 3'd2;
    localparam logic [2:0] S_FPRES = 3'd3;
    localparam logic [2:0] S_FWAIT = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    logic [2:0]            state, state_next;
    logic [PG_WIDTH-1:0]   mem [WORD_NUM];
    logic [MST_ID_W-1:0]   aw_id;
    logic [WADDR_W-1:0]    w_cnt;
    logic [ROW_W-1:0]      cell_r;
    logic [COL_W-1:0]      cell_c;
    logic [CELL_CNT_W-1:0] cell_cnt;
    logic [LANE_W-1:0]     lane;
    logic [3:0]            row_step;
    logic [1:0]            word_step;
    logic [CELL_WIDTH-1:0] cell_buf;
`ifdef FRAME_CELL_FETCH_HALO_EN
    logic [2*PG_WIDTH-1:0] win;
    logic [3*PG_WIDTH-1:0] window;
`else
    logic [PG_WIDTH-1:0]   window;
`endif
    logic                  aw_hs, w_hs, cell_hs, last_word, last_step, last_cell;
    int                    pix_row, beat, sub_col, cen_row;
    logic                  in_frame;
    logic [WADDR_W-1:0]    rd_addr;
    logic [PG_WIDTH-1:0]   rd_word;
    logic [SEG_W-1:0]      row_pix;
    logic                  unused_inputs;

    assign unused_inputs = ^{m_AWADDR_i, m_WLAST_i};

    assign aw_hs     = (state == S_IDLE) && m_AWVALID_i && m_AWREADY_o;
    assign w_hs      = (state == S_RECV) && m_WVALID_i && m_WREADY_o;
    assign cell_hs   = (state == S_FWAIT) && cell_ready_i[lane];
    assign last_word = (w_cnt == WADDR_W'(WORD_NUM - 1));
    assign last_step = (row_step == 4'(ROWS - 1)) && (word_step == 2'(WORDS - 1));
    assign last_cell = (cell_cnt == CELL_CNT_W'(CELL_NUM - 1));

    // Buffer read address for the current fetch step; out-of-frame reads give zero
    always_comb begin
        pix_row  = int'(cell_r) * int'(CELL_ROW_PNUM) - int'(HALO) + int'(row_step);
        beat     = int'(cell_c) / int'(CELLS_PER_PG) - int'(HALO) + int'(word_step);
        sub_col  = int'(cell_c) % int'(CELLS_PER_PG);
        cen_row  = int'(row_step) - int'(HALO);
        in_frame = (pix_row >= 0) && (pix_row < int'(FRAME_ROW_PNUM)) &&
                   (beat >= 0) && (beat < int'(FRAME_COL_PGNUM));
        rd_addr  = in_frame ? WADDR_W'(pix_row * int'(FRAME_COL_PGNUM) + beat) : '0;
        rd_word  = in_frame ? mem[rd_addr] : '0;
`ifdef FRAME_CELL_FETCH_HALO_EN
        window   = {rd_word, win};
`else
        window   = rd_word;
`endif
        row_pix  = SEG_W'(window >> (8 * (int'(HALO) * (int'(PG_PNUM) - 1) +
                                          sub_col * int'(CELL_COL_PNUM))));
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (aw_hs) state_next = S_RECV;
            S_RECV:  if (w_hs && last_word) state_next = S_FREAD;
            S_FREAD: if (last_step) state_next = S_FPRES;
            S_FPRES: state_next = S_FWAIT;
            S_FWAIT: if (cell_hs) begin
                         if (!last_cell) state_next = S_FREAD;
                         else if (m_BVALID_o && !m_BREADY_i) state_next = S_DRAIN;
                         else state_next = S_IDLE;
                     end
            S_DRAIN: if (!m_BVALID_o || m_BREADY_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) state <= S_IDLE;
        else            state <= state_next;
    end

    // Frame buffer write port
    always_ff @(posedge ACLK_i) begin
        if (w_hs) mem[w_cnt] <= m_WDATA_i;
    end

    // AXI handshakes, fetch counters, cell assembly and output registers
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            m_AWREADY_o  <= 1'b0;
            m_WREADY_o   <= 1'b0;
            m_BVALID_o   <= 1'b0;
            m_BID_o      <= '0;
            m_BRESP_o    <= '0;
            cell_data_o  <= '0;
            cell_valid_o <= '0;
            aw_id        <= '0;
            w_cnt        <= '0;
            cell_r       <= '0;
            cell_c       <= '0;
            cell_cnt     <= '0;
            lane         <= '0;
            row_step     <= '0;
            word_step    <= '0;
            cell_buf     <= '0;
`ifdef FRAME_CELL_FETCH_HALO_EN
            win          <= '0;
`endif
        end else begin
            m_AWREADY_o <= (state_next == S_IDLE);
            m_WREADY_o  <= (state_next == S_RECV);
            if (aw_hs) begin
                aw_id <= m_AWID_i;
                w_cnt <= '0;
            end
            if (w_hs) begin
                w_cnt <= w_cnt + 1'b1;
                if (last_word) begin
                    m_BVALID_o <= 1'b1;
                    m_BID_o    <= aw_id;
                    m_BRESP_o  <= '0;
                    cell_r     <= '0;
                    cell_c     <= '0;
                    cell_cnt   <= '0;
                    lane       <= '0;
                    row_step   <= '0;
                    word_step  <= '0;
                end
            end else if (m_BVALID_o && m_BREADY_i) begin
                m_BVALID_o <= 1'b0;
            end
            if (state == S_FREAD) begin
                if (word_step != 2'(WORDS - 1)) begin
                    word_step <= word_step + 1'b1;
`ifdef FRAME_CELL_FETCH_HALO_EN
                    win[int'(word_step) * PG_WIDTH +: PG_WIDTH] <= rd_word;
`endif
                end else begin
                    word_step <= '0;
                    row_step  <= last_step ? '0 : row_step + 1'b1;
`ifdef FRAME_CELL_FETCH_HALO_EN
                    if (row_step == 4'd0) begin
                        cell_buf[TOP_BASE +: CROW_W] <= row_pix[8 +: CROW_W];
                    end else if (row_step == 4'(ROWS - 1)) begin
                        cell_buf[BOT_BASE +: CROW_W] <= row_pix[8 +: CROW_W];
                    end else begin
                        cell_buf[cen_row * int'(CROW_W) +: CROW_W] <= row_pix[8 +: CROW_W];
                        cell_buf[int'(LEFT_BASE) + cen_row * 8 +: 8]  <= row_pix[0 +: 8];
                        cell_buf[int'(RIGHT_BASE) + cen_row * 8 +: 8] <= row_pix[SEG_W-8 +: 8];
                    end
`else
                    cell_buf[cen_row * int'(CROW_W) +: CROW_W] <= row_pix;
`endif
                end
            end
            if (state == S_FPRES) begin
                cell_data_o[int'(lane) * CELL_WIDTH +: CELL_WIDTH] <= cell_buf;
                cell_valid_o <= IP_AMT'(1) << lane;
            end
            if (cell_hs) begin
                cell_valid_o <= '0;
                cell_cnt     <= cell_cnt + 1'b1;
                lane         <= (lane == LANE_W'(IP_AMT - 1)) ? '0 : lane + 1'b1;
                if (cell_c == COL_W'(FRAME_COL_CNUM - 1)) begin
                    cell_c <= '0;
                    cell_r <= cell_r + 1'b1;
                end else begin
                    cell_c <= cell_c + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_cell_fetch.sv
// tb_frame_cell_fetch: writes frames over AXI, predicts every cell from a
// pixel model into a scoreboard queue and compares each delivered cell.
module tb_frame_cell_fetch;

    localparam int unsigned CW = 768;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2:0]     awid = '0;
    logic [31:0]    awaddr = '0;
    logic           awvalid = 1'b0;
    logic           awready;
    logic [255:0]   wdata = '0;
    logic           wlast = 1'b0;
    logic           wvalid = 1'b0;
    logic           wready;
    logic [2:0]     bid;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready = 1'b0;
    logic [CW-1:0]  cell_data;
    logic [0:0]     cell_valid;
    logic [0:0]     cell_ready = '0;

    int             n_checks = 0;
    int             n_fail = 0;
    logic [CW-1:0]  exp_q [$];

    frame_cell_fetch dut (
        .ACLK_i       (clk),
        .ARESETn_i    (rst_n),
        .m_AWID_i     (awid),
        .m_AWADDR_i   (awaddr),
        .m_AWVALID_i  (awvalid),
        .m_AWREADY_o  (awready),
        .m_WDATA_i    (wdata),
        .m_WLAST_i    (wlast),
        .m_WVALID_i   (wvalid),
        .m_WREADY_o   (wready),
        .m_BID_o      (bid),
        .m_BRESP_o    (bresp),
        .m_BVALID_o   (bvalid),
        .m_BREADY_i   (bready),
        .cell_data_o  (cell_data),
        .cell_valid_o (cell_valid),
        .cell_ready_i (cell_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Pixel model: pattern 0 is the plain test pattern, pattern 1 varies by row and column
    function automatic logic [7:0] px(input int r, input int c, input int pat);
        if (r < 0 || r >= 240 || c < 0 || c >= 320) return 8'd0;
        if (pat == 0) return 8'(7 - (c % 8));
        return 8'(r * 13 + c * 7 + 5);
    endfunction

    function automatic logic [255:0] beat_data(input int n, input int pat);
        logic [255:0] d;
        for (int j = 0; j < 32; j++) d[8*j +: 8] = px(n / 10, 32 * (n % 10) + j, pat);
        return d;
    endfunction

    function automatic logic [CW-1:0] exp_cell(input int i, input int pat);
        logic [CW-1:0] d;
        int rb, cb;
        d  = '0;
        rb = 8 * (i / 40);
        cb = 8 * (i % 40);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) d[8*(8*r+c) +: 8] = px(rb + r, cb + c, pat);
`ifdef FRAME_CELL_FETCH_HALO_EN
        for (int k = 0; k < 8; k++) begin
            d[8*(64+k) +: 8] = px(rb - 1, cb + k, pat);
            d[8*(72+k) +: 8] = px(rb + 8, cb + k, pat);
            d[8*(80+k) +: 8] = px(rb + k, cb - 1, pat);
            d[8*(88+k) +: 8] = px(rb + k, cb + 8, pat);
        end
`endif
        return d;
    endfunction

    task automatic send_aw(input logic [2:0] id);
        int   t;
        logic fire;
        t = 0;
        fire = 1'b0;
        awid = id;
        awvalid = 1'b1;
        while (!fire && t < 20) begin
            fire = awready;
            @(negedge clk);
            t++;
        end
        awvalid = 1'b0;
        check_eq("aw_handshake", CW'(fire), CW'(1));
    endtask

    task automatic send_frame(input int nbeats, input int pat, output int stalls);
        int k, t;
        k = 0;
        t = 0;
        stalls = 0;
        wvalid = 1'b1;
        while (k < nbeats && t < 3000) begin
            wdata = beat_data(k, pat);
            if (wready) k++;
            else stalls++;
            @(negedge clk);
            t++;
        end
        wvalid = 1'b0;
        check_eq("beats_accepted", CW'(k), CW'(nbeats));
    endtask

    task automatic drain_cells(output int got);
        int t;
        logic [CW-1:0] e;
        t = 0;
        got = 0;
        cell_ready = 1'b1;
        while (got < 1200 && t < 60000) begin
            if (cell_valid[0]) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("cell%0d", got), cell_data, e);
                end else begin
                    check_eq("cell_unexpected", CW'(got), CW'(0));
                end
                got++;
            end
            @(negedge clk);
            t++;
        end
    endtask

    task automatic wait_awready(input string tag);
        int t;
        t = 0;
        while (!awready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq(tag, CW'(awready), CW'(1));
    endtask

    initial begin
        int            stalls, got, t;
        logic          stable;
        logic [CW-1:0] d0;

        // Reset values
        #4;
        check_eq("rst_awready", CW'(awready), CW'(0));
        check_eq("rst_wready", CW'(wready), CW'(0));
        check_eq("rst_bvalid", CW'(bvalid), CW'(0));
        check_eq("rst_bid", CW'(bid), CW'(0));
        check_eq("rst_bresp", CW'(bresp), CW'(0));
        check_eq("rst_cell_valid", CW'(cell_valid), CW'(0));
        check_eq("rst_cell_data", cell_data, '0);
        #5 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("idle_awready", CW'(awready), CW'(1));

        // Frame 1: plain pattern
        send_aw(3'd3);
        check_eq("aw_drop", CW'(awready), CW'(0));
        check_eq("recv_wready", CW'(wready), CW'(1));
        send_frame(2400, 0, stalls);
        for (int i = 0; i < 1200; i++) exp_q.push_back(exp_cell(i, 0));
        check_eq("w_stalls", CW'(stalls), CW'(0));
        check_eq("wready_off", CW'(wready), CW'(0));
        check_eq("bvalid_set", CW'(bvalid), CW'(1));
        check_eq("bid", CW'(bid), CW'(3));
        check_eq("bresp", CW'(bresp), CW'(0));
        repeat (3) @(negedge clk);
        check_eq("bvalid_hold", CW'(bvalid), CW'(1));
        bready = 1'b1;
        @(negedge clk);
        check_eq("bvalid_clear", CW'(bvalid), CW'(0));

        // First cell: fixed expectations, then held under back-pressure
        t = 0;
        while (!cell_valid[0] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("cell0_valid", CW'(cell_valid), CW'(1));
        d0 = cell_data;
        check_eq("cell0_centre", CW'(d0[511:0]), CW'({8{64'h0001020304050607}}));
        check_eq("cell0_top", CW'(d0[575:512]), CW'(0));
        check_eq("cell0_bottom", CW'(d0[639:576]),
`ifdef FRAME_CELL_FETCH_HALO_EN
                 CW'(64'h0001020304050607));
`else
                 CW'(0));
`endif
        check_eq("cell0_left", CW'(d0[703:640]), CW'(0));
        check_eq("cell0_right", CW'(d0[767:704]),
`ifdef FRAME_CELL_FETCH_HALO_EN
                 CW'(64'h0707070707070707));
`else
                 CW'(0));
`endif
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (cell_valid !== 1'b1 || cell_data !== d0) stable = 1'b0;
        end
        check_eq("hold_stable", CW'(stable), CW'(1));
        drain_cells(got);
        check_eq("cells_frame1", CW'(got), CW'(1200));
        check_eq("queue_empty1", CW'(exp_q.size()), CW'(0));
        wait_awready("idle_after_frame1");
        check_eq("valid_low_idle", CW'(cell_valid), CW'(0));
        cell_ready = 1'b0;

        // Reset in the middle of a frame
        send_aw(3'd4);
        send_frame(1000, 1, stalls);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_awready", CW'(awready), CW'(0));
        check_eq("midrst_wready", CW'(wready), CW'(0));
        check_eq("midrst_bvalid", CW'(bvalid), CW'(0));
        check_eq("midrst_cell_valid", CW'(cell_valid), CW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("midrst_idle", CW'(awready), CW'(1));

        // Frame 2: varied pattern after the aborted frame
        send_aw(3'd5);
        send_frame(2400, 1, stalls);
        for (int i = 0; i < 1200; i++) exp_q.push_back(exp_cell(i, 1));
        check_eq("bvalid_f2", CW'(bvalid), CW'(1));
        check_eq("bid_f2", CW'(bid), CW'(5));
        drain_cells(got);
        check_eq("cells_frame2", CW'(got), CW'(1200));
        check_eq("queue_empty2", CW'(exp_q.size()), CW'(0));
        check_eq("bvalid_f2_clear", CW'(bvalid), CW'(0));
        wait_awready("idle_after_frame2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
